// File: rtl/mux_scan_n.sv
// Registered N-channel mux with host-loaded or round-robin select.
// Data and reported index are registered together so they stay coherent.
module mux_scan_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 100000000,
  parameter int DWELL_W  = 27
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      sel_load,
  input  logic                      auto_en,
  input  logic                      hold,
  output logic [WIDTH-1:0]          o,
  output logic [SEL_W-1:0]          o_sel,
  output logic                      o_valid,
  output logic                      step,
  output logic                      sel_err
);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    PAUSE  = 2'd2
  } state_t;

  localparam logic [SEL_W:0]     CH_N     = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(CHANNELS-1);
  localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL-1);

  state_t                       state;
  logic [SEL_W-1:0]             cur_sel;
  logic [DWELL_W-1:0]           cnt;
  logic [CHANNELS-1:0][WIDTH-1:0] ch;
  logic                         load_ok;
  logic                         load_bad;

  assign ch       = i;
  assign load_ok  = sel_load && ({1'b0, sel_in} < CH_N);
  assign load_bad = sel_load && !load_ok;

  // A legal load is applied last so it overrides a same-cycle dwell expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MANUAL;
      cur_sel <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        MANUAL: begin
          cnt <= '0;
          if (auto_en) state <= AUTO;
        end
        AUTO: begin
          if (!auto_en) begin
            state <= MANUAL;
            cnt   <= '0;
          end else if (hold) begin
            state <= PAUSE;
          end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            cur_sel <= (cur_sel == SEL_LAST) ? '0 : cur_sel + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PAUSE: begin
          if (!auto_en) begin
            state <= MANUAL;
            cnt   <= '0;
          end else if (!hold) begin
            state <= AUTO;
          end
        end
        default: begin
          state <= MANUAL;
          cnt   <= '0;
        end
      endcase
      if (load_ok) begin
        cur_sel <= sel_in;
        cnt     <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o       <= '0;
      o_sel   <= '0;
      o_valid <= 1'b0;
      step    <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      o       <= ch[cur_sel];
      o_sel   <= cur_sel;
      o_valid <= 1'b1;
      step    <= (cur_sel != o_sel);
      sel_err <= load_bad;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: reset, manual load, bad load,
// auto scan with wrap, pause, load-vs-expiry priority, reset mid-scan.
module tb_mux_scan_n;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4:0][7:0] ich;
  logic [2:0]      sel_in = '0;
  logic            sel_load = 1'b0;
  logic            auto_en = 1'b0;
  logic            hold = 1'b0;
  logic [7:0]      o;
  logic [2:0]      o_sel;
  logic            o_valid;
  logic            step;
  logic            sel_err;

  int n_chk = 0;
  int n_fail = 0;

  int         exp_sel [14] = '{3,3,3,3,3,4,4,4,4,0,0,0,0,1};
  logic [7:0] exp_o   [14] = '{8'h13,8'h13,8'h13,8'h13,8'h13,
                               8'h14,8'h14,8'hAA,8'hAA,
                               8'h10,8'h10,8'h10,8'h10,8'h11};

  mux_scan_n #(
    .WIDTH(8), .CHANNELS(5), .SEL_W(3), .DWELL(4), .DWELL_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i(ich),
    .sel_in(sel_in), .sel_load(sel_load),
    .auto_en(auto_en), .hold(hold),
    .o(o), .o_sel(o_sel), .o_valid(o_valid),
    .step(step), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 5; k++) ich[k] = 8'h10 + 8'(k);

    // reset held for three edges
    repeat (3) tick();
    chk("rst_o", 32'(o), 32'h0);
    chk("rst_sel", 32'(o_sel), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_o", 32'(o), 32'h10);
    chk("idle_sel", 32'(o_sel), 32'h0);
    chk("idle_valid", 32'(o_valid), 32'h1);
    for (int k = 0; k < 3; k++) begin
      chk("idle_step", 32'(step), 32'h0);
      tick();
    end

    // manual load of 3
    sel_in = 3'd3; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    chk("ld_sel_t", 32'(o_sel), 32'h0);
    tick();
    chk("ld_o", 32'(o), 32'h13);
    chk("ld_sel", 32'(o_sel), 32'h3);
    chk("ld_step", 32'(step), 32'h1);
    tick();
    chk("ld_step_off", 32'(step), 32'h0);
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    chk("reld_step0", 32'(step), 32'h0);
    tick();
    chk("reld_step1", 32'(step), 32'h0);

    // illegal select
    sel_in = 3'd6; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    chk("bad_err", 32'(sel_err), 32'h1);
    tick();
    chk("bad_err_off", 32'(sel_err), 32'h0);
    chk("bad_sel", 32'(o_sel), 32'h3);
    chk("bad_o", 32'(o), 32'h13);

    // auto scan 3,4,0,1 with data change on channel 4
    auto_en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("scan_sel", 32'(o_sel), 32'(exp_sel[k]));
      chk("scan_o", 32'(o), 32'(exp_o[k]));
      chk("scan_step", 32'(step),
          32'((k > 0) && (exp_sel[k] != exp_sel[k-1])));
      if (k == 6) ich[4] = 8'hAA;
    end
    ich[4] = 8'h14;

    // pause at o_sel=1, cnt=2
    tick();
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("pause_sel", 32'(o_sel), 32'h1);
    end
    hold = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("resume_sel", 32'(o_sel), 32'h1);
    end
    tick();
    chk("resume_adv", 32'(o_sel), 32'h2);
    chk("resume_step", 32'(step), 32'h1);

    // load 0 on the dwell-expiry edge
    tick();
    tick();
    sel_in = 3'd0; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("prio_sel", 32'(o_sel), 32'h0);
      if (k == 0) chk("prio_step", 32'(step), 32'h1);
    end
    tick();
    chk("prio_adv", 32'(o_sel), 32'h1);

    // reset while showing channel 2 in AUTO
    repeat (4) tick();
    chk("pre_rst_sel", 32'(o_sel), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o", 32'(o), 32'h0);
    chk("mid_rst_sel", 32'(o_sel), 32'h0);
    chk("mid_rst_valid", 32'(o_valid), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rescan_sel", 32'(o_sel), 32'h0);
    end
    tick();
    chk("rescan_adv", 32'(o_sel), 32'h1);
    chk("rescan_step", 32'(step), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
